// File: rtl/lmc_ram_ctrl.sv
// LMC main memory: DEPTH signed words, boot-image loader, req/ack access port,
// registered read data and address range checking. Boot image is a packed parameter.
module lmc_ram_ctrl #(
  parameter int unsigned DEPTH  = 100,
  parameter int unsigned DATA_W = 11,
  parameter int unsigned ADDR_W = 7,
  parameter logic [DEPTH*DATA_W-1:0] INIT_IMAGE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              reload,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  localparam logic [1:0] RD_HOLD  = 2'd0;
  localparam logic [1:0] RD_MEM   = 2'd1;
  localparam logic [1:0] RD_WDATA = 2'd2;
  localparam logic [1:0] RD_ZERO  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] rom [DEPTH];
  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              ack_nxt, err_nxt, busy_nxt;
  logic [1:0]        rd_sel_c;
  logic              in_range_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  // Unpack the boot image into one word per entry
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_rom
    assign rom[i] = INIT_IMAGE[i*DATA_W +: DATA_W];
  end

  // Unsigned compare with one spare bit so DEPTH == 2**ADDR_W also works
  assign in_range_c = ({1'b0, addr} < DEPTH_EXT);

  // Next-state, RAM write port and output selection
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    mem_we_c    = 1'b0;
    mem_addr_c  = ptr;
    mem_wdata_c = rom[ptr];
    ack_nxt     = 1'b0;
    err_nxt     = 1'b0;
    rd_sel_c    = RD_HOLD;
    case (state)
      ST_INIT: begin
        mem_we_c = 1'b1;
        if (ptr == LAST_PTR) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + ADDR_W'(1);
        end
      end
      default: begin
        if (req) begin
          ack_nxt = 1'b1;
          if (!in_range_c) begin
            err_nxt  = 1'b1;
            rd_sel_c = RD_ZERO;
          end else if (we) begin
            mem_we_c    = 1'b1;
            mem_addr_c  = addr;
            mem_wdata_c = wdata;
            rd_sel_c    = RD_WDATA;
          end else begin
            rd_sel_c = RD_MEM;
          end
        end
        // A same-cycle access is still served; the loader takes over next cycle
        if (reload) begin
          state_nxt = ST_INIT;
          ptr_nxt   = '0;
        end
      end
    endcase
    busy_nxt = (state_nxt == ST_INIT);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      ptr   <= '0;
      busy  <= 1'b1;
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      busy  <= busy_nxt;
      ack   <= ack_nxt;
      err   <= err_nxt;
      case (rd_sel_c)
        RD_MEM:   rdata <= mem[addr];
        RD_WDATA: rdata <= wdata;
        RD_ZERO:  rdata <= '0;
        default:  rdata <= rdata;
      endcase
    end
  end

  // Storage array, single write port
  always_ff @(posedge clk) begin
    if (mem_we_c && !reset) begin
      mem[mem_addr_c] <= mem_wdata_c;
    end
  end

endmodule

// File: tb/tb_lmc_ram_ctrl.sv
// Bench for lmc_ram_ctrl: directed accesses, reload and reset scenarios checked
// against a cycle-level behavioural model plus hand-computed literals.
module tb_lmc_ram_ctrl;

  localparam int unsigned DEPTH  = 100;
  localparam int unsigned DATA_W = 11;
  localparam int unsigned ADDR_W = 7;

  function automatic logic [DEPTH*DATA_W-1:0] make_image();
    logic [DEPTH*DATA_W-1:0] v;
    v = '0;
    v[0*DATA_W  +: DATA_W] = 11'd521;
    v[1*DATA_W  +: DATA_W] = 11'd122;
    v[2*DATA_W  +: DATA_W] = 11'd321;
    v[3*DATA_W  +: DATA_W] = 11'd902;
    v[21*DATA_W +: DATA_W] = 11'd10;
    v[22*DATA_W +: DATA_W] = 11'd2;
    v[50*DATA_W +: DATA_W] = 11'd300;
    v[99*DATA_W +: DATA_W] = 11'd777;
    return v;
  endfunction

  localparam logic [DEPTH*DATA_W-1:0] IMAGE = make_image();

  function automatic logic [DATA_W-1:0] img_word(input int i);
    return IMAGE[i*DATA_W +: DATA_W];
  endfunction

  logic              clk = 1'b0;
  logic              reset;
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              reload;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              busy;

  lmc_ram_ctrl #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_IMAGE(IMAGE)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .reload(reload), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a loader countdown plus a word array
  logic [DATA_W-1:0] mmem [DEPTH];
  int                load_left = 0;
  int                ld_idx    = 0;
  bit                live      = 1'b0;
  logic              exp_ack, exp_err, exp_busy;
  logic [DATA_W-1:0] exp_rdata;

  task automatic model_step();
    if (reset) begin
      live      = 1'b1;
      load_left = DEPTH;
      ld_idx    = 0;
      exp_busy  = 1'b1;
      exp_ack   = 1'b0;
      exp_err   = 1'b0;
      exp_rdata = '0;
    end else if (live) begin
      exp_ack = 1'b0;
      exp_err = 1'b0;
      if (load_left > 0) begin
        mmem[ld_idx] = img_word(ld_idx);
        ld_idx++;
        load_left--;
        exp_busy = (load_left > 0);
      end else begin
        if (req) begin
          exp_ack = 1'b1;
          if (int'(addr) >= int'(DEPTH)) begin
            exp_err   = 1'b1;
            exp_rdata = '0;
          end else if (we) begin
            mmem[addr] = wdata;
            exp_rdata  = wdata;
          end else begin
            exp_rdata = mmem[addr];
          end
        end
        if (reload) begin
          load_left = DEPTH;
          ld_idx    = 0;
          exp_busy  = 1'b1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare every cycle once the model has seen a reset
  initial forever begin
    @(negedge clk);
    if (live) begin
      check("busy",  32'(busy),  32'(exp_busy));
      check("ack",   32'(ack),   32'(exp_ack));
      check("err",   32'(err),   32'(exp_err));
      check("rdata", 32'(rdata), 32'(exp_rdata));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Drive one access at the current negedge, capture its response one cycle later
  task automatic access(input logic w, input int a, input logic [DATA_W-1:0] d,
                        output logic [DATA_W-1:0] rd, output logic ak, output logic er);
    req   = 1'b1;
    we    = w;
    addr  = ADDR_W'(a);
    wdata = d;
    @(negedge clk);
    rd = rdata;
    ak = ack;
    er = err;
    req = 1'b0;
    we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] rd;
    logic ak, er;
    int n;
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; reload = 1'b0;

    // 1) boot load length and first read
    do_reset();
    check("t1_busy_after_reset", 32'(busy), 32'd1);
    wait_busy(n);
    check("t1_busy_cycles", 32'(n), 32'd100);
    access(1'b0, 0, '0, rd, ak, er);
    check("t1_ack", 32'(ak), 32'd1);
    check("t1_rdata0", 32'(rd), 32'd521);
    check("t1_err", 32'(er), 32'd0);
    access(1'b0, 22, '0, rd, ak, er);
    check("t1_rdata22", 32'(rd), 32'd2);

    // 2) back-to-back write then read of a negative word
    access(1'b1, 50, 11'h7F9, rd, ak, er);
    check("t2_wr_ack", 32'(ak), 32'd1);
    check("t2_wr_rdata", 32'(rd), 32'h7F9);
    access(1'b0, 50, '0, rd, ak, er);
    check("t2_rd_ack", 32'(ak), 32'd1);
    check("t2_rd_rdata", 32'(rd), 32'h7F9);

    // 3) out-of-range addresses
    access(1'b1, 100, 11'd55, rd, ak, er);
    check("t3_a100_ack", 32'(ak), 32'd1);
    check("t3_a100_err", 32'(er), 32'd1);
    check("t3_a100_rdata", 32'(rd), 32'd0);
    access(1'b0, 127, '0, rd, ak, er);
    check("t3_a127_err", 32'(er), 32'd1);
    check("t3_a127_rdata", 32'(rd), 32'd0);
    access(1'b0, 99, '0, rd, ak, er);
    check("t3_a99_err", 32'(er), 32'd0);
    check("t3_a99_rdata", 32'(rd), 32'd777);

    // 4) requests and reload during the load are ignored
    do_reset();
    repeat (10) @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 7'd3; wdata = 11'd5; reload = 1'b1;
    @(negedge clk);
    check("t4_no_ack", 32'(ack), 32'd0);
    req = 1'b0; we = 1'b0; reload = 1'b0;
    wait_busy(n);
    check("t4_busy_cycles", 32'(n + 11), 32'd100);
    access(1'b0, 3, '0, rd, ak, er);
    check("t4_rdata3", 32'(rd), 32'd902);

    // 5) reset in the middle of the load restarts it
    do_reset();
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_busy(n);
    check("t5_busy_cycles", 32'(n), 32'd100);
    for (int a = 0; a < int'(DEPTH); a++) begin
      access(1'b0, a, '0, rd, ak, er);
      if (a == 0)  check("t5_rdata0", 32'(rd), 32'd521);
      if (a == 22) check("t5_rdata22", 32'(rd), 32'd2);
    end

    // 6) overwrite, then reload restores the image; access coinciding with reload is served
    access(1'b1, 0, 11'd999, rd, ak, er);
    access(1'b0, 0, '0, rd, ak, er);
    check("t6_rdata0_999", 32'(rd), 32'd999);
    reload = 1'b1;
    access(1'b1, 5, 11'd123, rd, ak, er);
    reload = 1'b0;
    check("t6_reload_ack", 32'(ak), 32'd1);
    check("t6_reload_rdata", 32'(rd), 32'd123);
    check("t6_reload_busy", 32'(busy), 32'd1);
    wait_busy(n);
    check("t6_busy_cycles", 32'(n), 32'd100);
    access(1'b0, 0, '0, rd, ak, er);
    check("t6_rdata0", 32'(rd), 32'd521);
    access(1'b0, 5, '0, rd, ak, er);
    check("t6_rdata5", 32'(rd), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
